// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_ctrl
//  Purpose  : Programmable clock-enable divider with a request/acknowledge
//             divisor-change handshake and a graceful, period-aligned stop.
//             A period counter runs 0..N-1 while enabled; CLK_EN marks the
//             last cycle of each period and CLK_DIV_OUT is a square wave
//             that is high for the first ceil(N/2) cycles of each period.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK_IN       in   1      single clock, rising-edge active
//    RESET_N      in   1      asynchronous active-low reset
//    EN_REQ       in   1      level request to run the divider
//    DIV_REQ      in   1      divisor change request, held until DIV_ACK
//    DIV_VAL      in   CNT_W  requested divisor, captured on acceptance
//    DIV_ACK      out  1      one-cycle acknowledge of a divisor request
//    DIV_ERR      out  1      with DIV_ACK: request rejected (DIV_VAL = 0)
//    CLK_EN       out  1      one-cycle pulse in the last cycle of a period
//    CLK_DIV_OUT  out  1      divided square-wave level
//    RUNNING      out  1      high while the divider is running or stopping
// ============================================================================
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             CLK_IN,
  input  logic             RESET_N,
  input  logic             EN_REQ,
  input  logic             DIV_REQ,
  input  logic [CNT_W-1:0] DIV_VAL,
  output logic             DIV_ACK,
  output logic             DIV_ERR,
  output logic             CLK_EN,
  output logic             CLK_DIV_OUT,
  output logic             RUNNING
);

  localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEF_DIV);

  // PEND is RUN with a divisor change waiting for the period boundary.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2,
    ST_PEND     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             req_seen_q, req_seen_d;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;
  logic             clk_en_q, clk_en_d;
  logic             clk_div_out_q, clk_div_out_d;
  logic             running_q, running_d;

  logic             w_running;
  logic             w_at_boundary;
  logic             w_accept;
  logic [CNT_W:0]   w_half;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    pend_div_d    = pend_div_q;
    pend_d        = pend_q;
    req_seen_d    = req_seen_q;
    div_ack_d     = 1'b0;
    div_err_d     = 1'b0;
    clk_en_d      = 1'b0;
    clk_div_out_d = 1'b0;
    running_d     = 1'b0;
    w_half        = '0;

    w_running     = (state_q != ST_IDLE);
    w_at_boundary = w_running && (cnt_q == (div_q - 1'b1));

    // A request is taken once per DIV_REQ assertion: req_seen_q stays set
    // until the requester drops DIV_REQ, so a request held high past its
    // acknowledge is never taken a second time.
    w_accept = DIV_REQ && !req_seen_q && !pend_q && !div_ack_q;

    if (!DIV_REQ) begin
      req_seen_d = 1'b0;
    end

    // Sequencing of the period counter and run/stop state.
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (EN_REQ) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_PEND: begin
        if (w_at_boundary) begin
          cnt_d = '0;
          // A stop request seen in the boundary cycle ends the run here;
          // the period it would wait for has just completed.
          state_d = EN_REQ ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = EN_REQ ? state_q : ST_STOPPING;
        end
      end

      ST_STOPPING: begin
        if (w_at_boundary) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // A pending divisor lands on the boundary, whether the block keeps
    // running or stops there; the acknowledge marks the first new cycle.
    if (w_at_boundary && pend_q) begin
      div_d     = pend_div_q;
      pend_d    = 1'b0;
      div_ack_d = 1'b1;
    end

    if (w_accept) begin
      req_seen_d = 1'b1;
      if (DIV_VAL == '0) begin
        div_ack_d = 1'b1;
        div_err_d = 1'b1;
      end else if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
        // Nothing is mid-period after this edge: apply at once.
        div_d     = DIV_VAL;
        div_ack_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = DIV_VAL;
        if (state_d == ST_RUN) begin
          state_d = ST_PEND;
        end
      end
    end

    // Outputs are computed from the next state so that the output flops
    // line up with the counter value of the cycle they are observed in.
    running_d     = (state_d != ST_IDLE);
    w_half        = ({1'b0, div_d} + 1'b1) >> 1;
    clk_en_d      = running_d && (cnt_d == (div_d - 1'b1));
    clk_div_out_d = running_d && ({1'b0, cnt_d} < w_half);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      div_q         <= C_DEF_DIV;
      pend_div_q    <= '0;
      pend_q        <= 1'b0;
      req_seen_q    <= 1'b0;
      div_ack_q     <= 1'b0;
      div_err_q     <= 1'b0;
      clk_en_q      <= 1'b0;
      clk_div_out_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      pend_div_q    <= pend_div_d;
      pend_q        <= pend_d;
      req_seen_q    <= req_seen_d;
      div_ack_q     <= div_ack_d;
      div_err_q     <= div_err_d;
      clk_en_q      <= clk_en_d;
      clk_div_out_q <= clk_div_out_d;
      running_q     <= running_d;
    end
  end

  assign DIV_ACK     = div_ack_q;
  assign DIV_ERR     = div_err_q;
  assign CLK_EN      = clk_en_q;
  assign CLK_DIV_OUT = clk_div_out_q;
  assign RUNNING     = running_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_ctrl
//  Purpose  : Self-checking bench for clk_div_ctrl. A reference model steps
//             on every rising edge and queues the expected outputs; a monitor
//             on the falling edge pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_ctrl;

  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 2;

  logic             CLK_IN  = 1'b0;
  logic             RESET_N = 1'b0;
  logic             EN_REQ  = 1'b0;
  logic             DIV_REQ = 1'b0;
  logic [CNT_W-1:0] DIV_VAL = '0;
  logic             DIV_ACK;
  logic             DIV_ERR;
  logic             CLK_EN;
  logic             CLK_DIV_OUT;
  logic             RUNNING;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .CLK_IN      (CLK_IN),
    .RESET_N     (RESET_N),
    .EN_REQ      (EN_REQ),
    .DIV_REQ     (DIV_REQ),
    .DIV_VAL     (DIV_VAL),
    .DIV_ACK     (DIV_ACK),
    .DIV_ERR     (DIV_ERR),
    .CLK_EN      (CLK_EN),
    .CLK_DIV_OUT (CLK_DIV_OUT),
    .RUNNING     (RUNNING)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct packed {
    logic ack;
    logic err;
    logic en;
    logic dout;
    logic run;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, expv);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: mode 0 = idle, 1 = running, 2 = finishing last period.
  // --------------------------------------------------------------------------
  int m_mode;
  int m_pos;
  int m_n;
  bit m_pend;
  int m_pend_val;
  bit m_blocked;
  bit m_ack_prev;

  always @(posedge CLK_IN) begin : model
    exp_t e;
    int   next_mode;
    int   val;
    bit   boundary;
    bit   accept;
    bit   ack;
    bit   err;
    e = '0;
    if (!RESET_N) begin
      m_mode = 0; m_pos = 0; m_n = DEF_DIV; m_pend = 0;
      m_pend_val = 0; m_blocked = 0; m_ack_prev = 0;
    end else begin
      val      = int'(DIV_VAL);
      boundary = (m_mode != 0) && (m_pos == m_n - 1);
      accept   = DIV_REQ && !m_blocked && !m_pend && !m_ack_prev;
      if (!DIV_REQ) m_blocked = 0;
      ack = 0; err = 0;
      if (m_mode == 0) begin
        next_mode = EN_REQ ? 1 : 0;
        m_pos = 0;
      end else if (boundary) begin
        next_mode = (m_mode == 2 || !EN_REQ) ? 0 : 1;
        m_pos = 0;
        if (m_pend) begin
          m_n = m_pend_val; m_pend = 0; ack = 1;
        end
      end else begin
        next_mode = (m_mode == 2 || !EN_REQ) ? 2 : 1;
        m_pos = m_pos + 1;
      end
      if (accept) begin
        m_blocked = 1;
        if (val == 0) begin
          ack = 1; err = 1;
        end else if (m_mode == 0 || next_mode == 0) begin
          m_n = val; ack = 1;
        end else begin
          m_pend = 1; m_pend_val = val;
        end
      end
      m_mode     = next_mode;
      m_ack_prev = ack;
      e.run  = (m_mode != 0);
      e.en   = (m_mode != 0) && (m_pos == m_n - 1);
      e.dout = (m_mode != 0) && (m_pos < (m_n + 1) / 2);
      e.ack  = ack;
      e.err  = err;
    end
    exp_q.push_back(e);
    started = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge CLK_IN) begin : monitor
    exp_t e;
    if (started) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t: got empty queue, expected an entry", $time);
      end else begin
        e = exp_q.pop_front();
        if (!RESET_N) e = '0;
        chk("RUNNING",     RUNNING,     e.run);
        chk("CLK_EN",      CLK_EN,      e.en);
        chk("CLK_DIV_OUT", CLK_DIV_OUT, e.dout);
        chk("DIV_ACK",     DIV_ACK,     e.ack);
        chk("DIV_ERR",     DIV_ERR,     e.err);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the rising edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK_IN);
    #2;
  endtask

  task automatic request(input int v, input int hold_extra, input bit stop_after);
    bit got;
    got     = 1'b0;
    DIV_REQ = 1'b1;
    DIV_VAL = CNT_W'(v);
    for (int k = 0; k < 700 && !got; k++) begin
      tick();
      if (k == 0 && stop_after) EN_REQ = 1'b0;
      if (DIV_ACK) got = 1'b1;
      else DIV_VAL = CNT_W'($urandom_range(0, 255));
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout at %0t: got no DIV_ACK, expected one for value %0d", $time, v);
    end
    repeat (hold_extra) tick();
    DIV_REQ = 1'b0;
    tick();
  endtask

  task automatic wait_clk_en();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      tick();
      if (CLK_EN) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL clk_en_timeout at %0t: got no CLK_EN, expected a pulse", $time);
    end
  endtask

  // Assert reset mid-cycle and confirm the outputs clear before any edge.
  task automatic reset_mid();
    #1 RESET_N = 1'b0;
    #1;
    chk("async_RUNNING",     RUNNING,     1'b0);
    chk("async_CLK_EN",      CLK_EN,      1'b0);
    chk("async_CLK_DIV_OUT", CLK_DIV_OUT, 1'b0);
    chk("async_DIV_ACK",     DIV_ACK,     1'b0);
    chk("async_DIV_ERR",     DIV_ERR,     1'b0);
    DIV_REQ = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog at %0t: got no finish, expected end of test", $time);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin : stimulus
    int wait_cnt;
    int hold;
    wait_cnt = 0;
    hold     = 0;

    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (3) tick();

    // Default divisor after reset.
    EN_REQ = 1'b1;
    repeat (10) tick();

    // Live change 4 -> 3, request raised so it is sampled at counter 1.
    request(4, 0, 1'b0);
    repeat (8) tick();
    wait_clk_en();
    tick();
    request(3, 0, 1'b0);
    repeat (10) tick();

    // Zero divisor while running with N = 5.
    request(5, 0, 1'b0);
    repeat (12) tick();
    request(0, 0, 1'b0);
    repeat (12) tick();

    // Graceful stop at counter 2 of N = 6.
    request(6, 0, 1'b0);
    repeat (8) tick();
    wait_clk_en();
    tick();
    tick();
    EN_REQ = 1'b0;
    repeat (10) tick();

    // Re-enable while stopping: must pass through idle.
    EN_REQ = 1'b1;
    repeat (7) tick();
    EN_REQ = 1'b0;
    tick();
    EN_REQ = 1'b1;
    repeat (14) tick();

    // Request accepted while stopping.
    EN_REQ = 1'b0;
    tick();
    request(3, 0, 1'b0);
    repeat (5) tick();

    // Divisor change and stop landing on the same boundary.
    EN_REQ = 1'b1;
    request(7, 0, 1'b0);
    repeat (9) tick();
    request(4, 0, 1'b1);
    repeat (6) tick();

    // Held request past its acknowledge.
    EN_REQ = 1'b1;
    request(4, 2, 1'b0);
    repeat (10) tick();

    // Reset abort with a change pending on N = 8.
    request(8, 0, 1'b0);
    repeat (11) tick();
    DIV_REQ = 1'b1;
    DIV_VAL = CNT_W'(5);
    tick();
    tick();
    reset_mid();
    repeat (12) tick();

    // Boundary sweep: N = 1 and N = 255.
    request(1, 0, 1'b0);
    repeat (10) tick();
    request(255, 0, 1'b0);
    repeat (600) tick();
    request(7, 0, 1'b0);
    repeat (10) tick();

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0) EN_REQ = ~EN_REQ;
      if (DIV_REQ) begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) DIV_REQ = 1'b0;
        end else if (DIV_ACK) begin
          hold = $urandom_range(0, 2);
          if (hold == 0) DIV_REQ = 1'b0;
        end else begin
          wait_cnt++;
          DIV_VAL = CNT_W'($urandom_range(0, 10));
          if (wait_cnt > 700) begin
            checks++;
            errors++;
            $display("FAIL rand_ack_timeout at %0t: got no DIV_ACK, expected one", $time);
            DIV_REQ  = 1'b0;
            wait_cnt = 0;
          end
        end
      end else if ($urandom_range(0, 11) == 0) begin
        DIV_REQ  = 1'b1;
        DIV_VAL  = ($urandom_range(0, 7) == 0) ? '0 : CNT_W'($urandom_range(1, 10));
        wait_cnt = 0;
      end
      if ($urandom_range(0, 399) == 0) begin
        reset_mid();
        hold = 0;
      end
    end

    EN_REQ  = 1'b0;
    DIV_REQ = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
